// File: rtl/vpu_multi_cntr.sv
// Multi-channel programmable latency counter: per-channel IDLE/RUN/DONE FSM with start handshake.
// Optional per-channel abort input enabled by defining VPU_CNTR_ABORT_EN.
module vpu_multi_cntr #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start_valid_i,
  input  logic [NUM_CH*CNT_W-1:0] start_len_i,
`ifdef VPU_CNTR_ABORT_EN
  input  logic [NUM_CH-1:0]       abort_i,
`endif
  output logic [NUM_CH-1:0]       start_ready_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic                    all_idle_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [NUM_CH-1:0] abort_w;

`ifdef VPU_CNTR_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len;
    logic             accept;

    assign len              = start_len_i[c*CNT_W +: CNT_W];
    assign start_ready_o[c] = ((state_q == S_IDLE) | (state_q == S_DONE)) & ~abort_w[c];
    assign accept           = start_valid_i[c] & start_ready_o[c];
    assign done_o[c]        = (state_q == S_DONE);
    assign busy_o[c]        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // A run of L cycles loads L-1 so the RUN state lasts exactly L cycles; L=0 skips RUN.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (len == '0) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              state_d = S_RUN;
              cnt_d   = len - CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (abort_w[c]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign all_idle_o = ~(|busy_o);

endmodule
